// File: rtl/alu_pkg.sv
// Shared definitions for the ALU write-back stage: opcode encodings,
// the stage state enum and the write-opcode decoder.
package alu_pkg;

    localparam int OP_BITS = 5;

    localparam logic [OP_BITS-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_BITS-1:0] OP_LV   = 5'd1;
    localparam logic [OP_BITS-1:0] OP_MLT  = 5'd2;
    localparam logic [OP_BITS-1:0] OP_DIV  = 5'd3;
    localparam logic [OP_BITS-1:0] OP_REST = 5'd4;
    localparam logic [OP_BITS-1:0] OP_SUM  = 5'd5;
    localparam logic [OP_BITS-1:0] OP_CP   = 5'd6;
    localparam logic [OP_BITS-1:0] OP_B    = 5'd7;
    localparam logic [OP_BITS-1:0] OP_BEG  = 5'd8;
    localparam logic [OP_BITS-1:0] OP_SLR  = 5'd9;
    localparam logic [OP_BITS-1:0] OP_GP   = 5'd10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } wb_state_e;

    // True for every opcode that produces a register-file write.
    function automatic logic is_write(input logic [OP_BITS-1:0] op);
        case (op)
            OP_LV, OP_MLT, OP_DIV, OP_REST,
            OP_SUM, OP_CP, OP_SLR, OP_GP: is_write = 1'b1;
            default:                      is_write = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_flush_ctr.sv
// Loadable down-counter that tracks how many wrong-path beats remain to be
// discarded after a taken branch. Saturates at zero and exposes a zero flag.
module wb_flush_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Load has priority over decrement; never wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/alu_wb_stage.sv
// Write-back stage behind the ALU: registers the ALU outputs, drives the
// register-file write port, redirects the PC on taken branches and discards
// wrong-path beats during a fixed flush window.
// Optional forwarding tap (fwd_*) is built when ALU_WB_FWD_EN is defined.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 7,
    parameter int OP_W         = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [REG_W-1:0]  br_tgt_in,
    input  logic              wb_ready,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pc_load,
    output logic [REG_W-1:0]  pc_target,
`ifdef ALU_WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              flush
);

    localparam int CTR_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    wb_state_e         state_d, state_q;
    logic              s1_valid_d, s1_valid_q;
    logic [OP_W-1:0]   s1_op_d, s1_op_q;
    logic [REG_W-1:0]  s1_rd_d, s1_rd_q;
    logic [DATA_W-1:0] s1_result_d, s1_result_q;
    logic [REG_W-1:0]  s1_tgt_d, s1_tgt_q;

    logic              s1_is_wr;
    logic              s1_taken;
    logic              s1_retire;
    logic              in_flush;
    logic              capture;
    logic              discard;
    logic [CTR_W-1:0]  ctr_count;
    logic              ctr_zero;

    // Decode what sits in S1 and derive the handshake. A retiring taken branch
    // refuses the incoming beat so that it becomes the first discarded one.
    always_comb begin
        s1_is_wr  = s1_valid_q & is_write(s1_op_q);
        s1_taken  = s1_valid_q & ((s1_op_q == OP_B) |
                                  ((s1_op_q == OP_BEG) & s1_result_q[0]));
        s1_retire = s1_valid_q & (~s1_is_wr | wb_ready);
        in_flush  = (state_q == FLUSH);
        in_ready  = in_flush | ((~s1_valid_q | s1_retire) & ~s1_taken);
        capture   = in_valid & in_ready & ~in_flush;
        discard   = in_valid & in_flush;
    end

    // Next contents of the stage register: load on capture, empty on retire.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_rd_d     = s1_rd_q;
        s1_result_d = s1_result_q;
        s1_tgt_d    = s1_tgt_q;
        if (capture) begin
            s1_valid_d  = 1'b1;
            s1_op_d     = op_in;
            s1_rd_d     = rd_in;
            s1_result_d = result_in;
            s1_tgt_d    = br_tgt_in;
        end else if (s1_retire) begin
            s1_valid_d  = 1'b0;
        end
    end

    // Stage state transitions; the flush window ends on the beat that empties the counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (s1_taken && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                end else if (s1_is_wr && !wb_ready) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (wb_ready) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (ctr_zero || (discard && (ctr_count == CTR_W'(1)))) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and stage register, cleared asynchronously; a held instruction is lost on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_rd_q     <= '0;
            s1_result_q <= '0;
            s1_tgt_q    <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_rd_q     <= s1_rd_d;
            s1_result_q <= s1_result_d;
            s1_tgt_q    <= s1_tgt_d;
        end
    end

    wb_flush_ctr #(
        .W (CTR_W)
    ) u_flush_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (s1_taken),
        .load_val (CTR_W'(FLUSH_CYCLES)),
        .dec      (discard),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

    // Output drive; address/data/target are gated so non-writing ops show nothing.
    always_comb begin
        wr_en     = s1_is_wr & wb_ready;
        wr_addr   = s1_is_wr ? s1_rd_q : '0;
        wr_data   = s1_is_wr ? s1_result_q : '0;
        pc_load   = s1_taken;
        pc_target = s1_taken ? s1_tgt_q : '0;
        flush     = in_flush;
    end

`ifdef ALU_WB_FWD_EN
    // Bypass tap: exposes a pending write, including while it is held.
    always_comb begin
        fwd_valid = s1_is_wr;
        fwd_addr  = s1_is_wr ? s1_rd_q : '0;
        fwd_data  = s1_is_wr ? s1_result_q : '0;
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage (default parameters,
// FLUSH_CYCLES = 2). Forwarding checks are compiled in with ALU_WB_FWD_EN.
module tb_alu_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op_in;
    logic [6:0]  rd_in;
    logic [31:0] result_in;
    logic [6:0]  br_tgt_in;
    logic        wb_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pc_load;
    logic [6:0]  pc_target;
    logic        flush;
`ifdef ALU_WB_FWD_EN
    logic        fwd_valid;
    logic [6:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int checks;
    int errors;

    alu_wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_in     (op_in),
        .rd_in     (rd_in),
        .result_in (result_in),
        .br_tgt_in (br_tgt_in),
        .wb_ready  (wb_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_load   (pc_load),
        .pc_target (pc_target),
`ifdef ALU_WB_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
`endif
        .flush     (flush)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one ALU beat and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [6:0] rd,
                                 input logic [31:0] res, input logic [6:0] tgt);
        in_valid  = v;
        op_in     = op;
        rd_in     = rd;
        result_in = res;
        br_tgt_in = tgt;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        wb_ready = 1'b0;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_pc_load", pc_load, 0);
        checkOutput("rst_flush", flush, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // sum rd=3 result=7, written one cycle after capture
        step;
        wb_ready = 1'b1;
        applyStimulus(1'b1, 5'd5, 7'd3, 32'h7, 7'd0);
        checkOutput("sum_in_ready", in_ready, 1);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("sum_wr_en", wr_en, 1);
        checkOutput("sum_wr_addr", wr_addr, 3);
        checkOutput("sum_wr_data", wr_data, 7);
        step;
        checkOutput("sum_wr_en_once", wr_en, 0);

        // mlt rd=9 held for 3 cycles by wb_ready=0, next instruction waits
        wb_ready = 1'b0;
        applyStimulus(1'b1, 5'd2, 7'd9, 32'h40, 7'd0);
        step;
        applyStimulus(1'b1, 5'd5, 7'd10, 32'h55, 7'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_wr_en", wr_en, 0);
            checkOutput("hold_wr_addr", wr_addr, 9);
            checkOutput("hold_wr_data", wr_data, 32'h40);
            step;
        end
        wb_ready = 1'b1;
        #1;
        checkOutput("release_wr_en", wr_en, 1);
        checkOutput("release_wr_addr", wr_addr, 9);
        checkOutput("release_in_ready", in_ready, 1);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("next_wr_en", wr_en, 1);
        checkOutput("next_wr_addr", wr_addr, 10);
        checkOutput("next_wr_data", wr_data, 32'h55);
        step;

        // B tgt=0x15, then sum rd=4 / rest rd=5 discarded, CP rd=6 written
        applyStimulus(1'b1, 5'd7, 7'd0, 32'd0, 7'h15);
        step;
        applyStimulus(1'b1, 5'd5, 7'd4, 32'h44, 7'd0);
        checkOutput("b_pc_load", pc_load, 1);
        checkOutput("b_pc_target", pc_target, 7'h15);
        checkOutput("b_in_ready", in_ready, 0);
        checkOutput("b_flush_pre", flush, 0);
        step;
        checkOutput("fl1_flush", flush, 1);
        checkOutput("fl1_in_ready", in_ready, 1);
        checkOutput("fl1_pc_load", pc_load, 0);
        step;
        applyStimulus(1'b1, 5'd4, 7'd5, 32'h55, 7'd0);
        checkOutput("fl2_flush", flush, 1);
        checkOutput("fl2_wr_en", wr_en, 0);
        step;
        applyStimulus(1'b1, 5'd6, 7'd6, 32'h66, 7'd0);
        checkOutput("fl_end_flush", flush, 0);
        checkOutput("fl_end_wr_en", wr_en, 0);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("cp_wr_en", wr_en, 1);
        checkOutput("cp_wr_addr", wr_addr, 6);
        checkOutput("cp_wr_data", wr_data, 32'h66);
        step;

        // BEG not taken, then BEG taken
        applyStimulus(1'b1, 5'd8, 7'd0, 32'd0, 7'h20);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("beg0_pc_load", pc_load, 0);
        checkOutput("beg0_wr_en", wr_en, 0);
        step;
        checkOutput("beg0_flush", flush, 0);
        applyStimulus(1'b1, 5'd8, 7'd0, 32'd1, 7'h20);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("beg1_pc_load", pc_load, 1);
        checkOutput("beg1_pc_target", pc_target, 7'h20);
        step;
        checkOutput("beg1_flush", flush, 1);

        // Reset during FLUSH
        #2 rst = 1'b0;
        #1;
        checkOutput("rstfl_flush", flush, 0);
        checkOutput("rstfl_in_ready", in_ready, 1);
        checkOutput("rstfl_pc_load", pc_load, 0);
        @(negedge clk);
        rst = 1'b1;
        step;
        checkOutput("rstfl_after_flush", flush, 0);

        // Reset during HOLD
        wb_ready = 1'b0;
        applyStimulus(1'b1, 5'd3, 7'd11, 32'h99, 7'd0);
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        step;
        checkOutput("hold2_wr_addr", wr_addr, 11);
        checkOutput("hold2_in_ready", in_ready, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rsthd_wr_addr", wr_addr, 0);
        checkOutput("rsthd_wr_data", wr_data, 0);
        checkOutput("rsthd_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        step;
        wb_ready = 1'b1;
        #1;
        checkOutput("rsthd_lost_wr_en", wr_en, 0);
        checkOutput("rsthd_after_in_ready", in_ready, 1);

        // NOP then illegal opcode 15 back-to-back, then LV
        applyStimulus(1'b1, 5'd0, 7'd1, 32'h11, 7'd0);
        step;
        applyStimulus(1'b1, 5'd15, 7'd2, 32'h23, 7'h7F);
        checkOutput("nop_wr_en", wr_en, 0);
        checkOutput("nop_pc_load", pc_load, 0);
        checkOutput("nop_in_ready", in_ready, 1);
`ifdef ALU_WB_FWD_EN
        checkOutput("nop_fwd_valid", fwd_valid, 0);
`endif
        step;
        applyStimulus(1'b1, 5'd1, 7'd3, 32'h33, 7'd0);
        checkOutput("ill_wr_en", wr_en, 0);
        checkOutput("ill_pc_load", pc_load, 0);
        checkOutput("ill_wr_addr", wr_addr, 0);
        checkOutput("ill_pc_target", pc_target, 0);
`ifdef ALU_WB_FWD_EN
        checkOutput("ill_fwd_valid", fwd_valid, 0);
`endif
        step;
        applyStimulus(1'b1, 5'd9, 7'd0, 32'hABCD, 7'd0);
        checkOutput("lv_wr_en", wr_en, 1);
        checkOutput("lv_wr_addr", wr_addr, 3);
        checkOutput("lv_wr_data", wr_data, 32'h33);
`ifdef ALU_WB_FWD_EN
        checkOutput("lv_fwd_valid", fwd_valid, 1);
        checkOutput("lv_fwd_addr", fwd_addr, 3);
        checkOutput("lv_fwd_data", fwd_data, 32'h33);
`endif

        // slr to index 0 is a real write
        step;
        applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 7'd0);
        checkOutput("r0_wr_en", wr_en, 1);
        checkOutput("r0_wr_addr", wr_addr, 0);
        checkOutput("r0_wr_data", wr_data, 32'hABCD);
        step;
        checkOutput("idle_wr_en", wr_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
